// File: rtl/slave_vldrdy_pkg.sv
// Shared types and helpers for the valid/ready sink and its future source-side twin.
package slave_vldrdy_pkg;

  typedef enum logic [1:0] {
    RDY_ALWAYS   = 2'd0,
    RDY_RANDOM   = 2'd1,
    RDY_PERIODIC = 2'd2,
    RDY_NEVER    = 2'd3
  } rdy_mode_e;

  typedef enum logic {
    CHK_IDLE = 1'b0,
    CHK_WAIT = 1'b1
  } chk_state_e;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam int          LFSR16_W    = 16;
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  // Increment that sticks at max instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
    return (value >= max) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR with enable. A zero seed is replaced by 1 so the
// register can never lock up in the all-zero state.
module lfsr_gen
  import slave_vldrdy_pkg::*;
#(
  parameter int                LFSR_W = LFSR16_W,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(LFSR16_TAPS);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  // Shift left one bit per enabled cycle, feeding back the XOR of the tapped bits.
  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED_EFF;
    end else if (en) begin
      value <= {value[LFSR_W-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/slave_vldrdy_ctrl.sv
// Valid/ready stream sink: registered backpressure generator (always / LFSR
// random / periodic / never), protocol checker and saturating statistics.
// Optional simulation logging is enabled by defining SLAVE_VLDRDY_CTRL_LOG_EN.
module slave_vldrdy_ctrl
  import slave_vldrdy_pkg::*;
#(
  parameter int          DWIDTH = 8,
  parameter int          CWIDTH = 32,
  parameter int unsigned SEED   = 32'hACE1,
  parameter int          LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [1:0]        cfg_mode,
  input  logic [7:0]        cfg_thresh,
  input  logic [7:0]        cfg_period,
  input  logic              dst_val,
  output logic              dst_rdy,
  input  logic [DWIDTH-1:0] dst_data,
  output logic [CWIDTH-1:0] beat_cnt,
  output logic [CWIDTH-1:0] stall_cnt,
  output logic [CWIDTH-1:0] err_cnt,
  output logic              err_flag
);

  localparam logic [63:0] CNT_MAX = 64'((65'd1 << CWIDTH) - 65'd1);

  rdy_mode_e         mode;
  logic [LFSR_W-1:0] lfsr;
  logic [7:0]        pcnt;
  logic              rdy_d;
  chk_state_e        state_q, state_d;
  logic [DWIDTH-1:0] hold_q;
  logic              capture;
  logic              viol;
  logic              handshake;
  logic              stall;
  logic              unused_lfsr_hi;

  assign mode           = rdy_mode_e'(cfg_mode);
  assign handshake      = cfg_en && dst_val && dst_rdy;
  assign stall          = cfg_en && dst_val && !dst_rdy;
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:8];

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .SEED   (LFSR_W'(SEED))
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cfg_en),
    .value (lfsr)
  );

  // Next ready value from the selected mode; disabled means not ready.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    rdy_d = 1'b0;
    if (cfg_en) begin
      unique case (mode)
        RDY_ALWAYS:   rdy_d = 1'b1;
        RDY_RANDOM:   rdy_d = (lfsr[7:0] < cfg_thresh);
        RDY_PERIODIC: rdy_d = (pcnt == 8'd0);
        RDY_NEVER:    rdy_d = 1'b0;
      endcase
    end
  end

  // Period counter 0..cfg_period; the >= compare also wraps when the period is lowered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= 8'd0;
    end else if (cfg_en) begin
      pcnt <= (pcnt >= cfg_period) ? 8'd0 : pcnt + 8'd1;
    end
  end

  // Ready is registered so no input reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_rdy <= 1'b0;
    end else begin
      dst_rdy <= rdy_d;
    end
  end

  // Checker next state: a stalled beat must stay valid with unchanged data until accepted.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    viol    = 1'b0;
    if (!cfg_en) begin
      state_d = CHK_IDLE;
    end else begin
      unique case (state_q)
        CHK_IDLE: begin
          if (dst_val && !dst_rdy) begin
            capture = 1'b1;
            state_d = CHK_WAIT;
          end
        end
        CHK_WAIT: begin
          if (!dst_val) begin
            viol    = 1'b1;
            state_d = CHK_IDLE;
          end else if (dst_data != hold_q) begin
            viol    = 1'b1;
            capture = 1'b1;
          end else if (dst_rdy) begin
            state_d = CHK_IDLE;
          end
        end
      endcase
    end
  end

  // Checker state and the data snapshot of the stalled beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CHK_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        hold_q <= dst_data;
      end
    end
  end

  // Saturating statistics and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
      err_cnt   <= '0;
      err_flag  <= 1'b0;
    end else begin
      if (handshake) beat_cnt  <= CWIDTH'(sat_inc(64'(beat_cnt), CNT_MAX));
      if (stall)     stall_cnt <= CWIDTH'(sat_inc(64'(stall_cnt), CNT_MAX));
      if (viol) begin
        err_cnt  <= CWIDTH'(sat_inc(64'(err_cnt), CNT_MAX));
        err_flag <= 1'b1;
      end
    end
  end

`ifdef SLAVE_VLDRDY_CTRL_LOG_EN
  // Log accepted beats in binary and report every violation.
  always @(posedge clk) begin
    if (rst_n) begin
      if (handshake) $display("%b", dst_data);
      if (viol) begin
        $error("%0t: beat_cnt=%0d violation: %s", $time, beat_cnt,
               dst_val ? "data changed while stalled" : "valid dropped while stalled");
      end
    end
  end
`endif

endmodule
